deskew_collector: RTL
=====================

# deskew_collector

Output-side counterpart of the input skew delay lines. It takes the diagonally skewed lane outputs of the systolic array, where lane i of a word arrives i cycles after lane 0, and realigns them into one wide word. Each aligned word is queued in a small FIFO and handed to the downstream consumer over a valid/ready handshake. It sits between the array's bottom edge and the result write-back path.

## Interface
- LANES, 4, number of lanes (≥2)
- WIDTH, 8, bits per lane
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  lane-0 element of a new word is present this cycle
- in_data  in  LANES*WIDTH  lane i in bits [i*WIDTH +: WIDTH]; lane i valid i cycles after in_valid
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  LANES*WIDTH  head-of-FIFO aligned word, lane order as in_data
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Deskew:
  - Lane i passes through a zero-reset shift register of LANES-1-i stages.
  - Lane LANES-1 has no stage and is taken combinationally from in_data.
- Valid tracking: in_valid passes through a LANES-1 stage shift register. Its output is push, and marks the cycle in which all lanes of a word are aligned.
- Push: on push, {lane LANES-1 input, delayed lanes} is written at wr_ptr and wr_ptr advances.
- Pop: a handshake occurs when out_valid && out_ready. rd_ptr advances on that handshake.
- Pointers:
  - $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Wrap naturally modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr.
- Full (count==DEPTH):
  - Push with simultaneous pop: both succeed, count unchanged.
  - Push without pop: the word is dropped, pointers are unchanged, and overflow is set.
- Empty:
  - out_valid=0 and out_ready is ignored.
  - No fall-through: a push into an empty FIFO becomes visible next cycle.
- out_data = mem[rd_ptr]. The value is undefined-but-stable when empty; the bench must not check it.
- The array cannot stall, so upstream is never back-pressured; overflow is the only loss mechanism.
- Reset:
  - Clears the delay lines, the valid pipeline, both pointers and overflow.
  - FIFO storage is not cleared.
  - Words in flight or queued at reset are discarded.
  - in_valid is ignored while reset=1.

## Timing
- Reset values: out_valid=0, count=0, overflow=0, out_data=don't-care.
- Latency: in_valid at cycle t puts the word at the FIFO head with out_valid=1 in cycle t+LANES, provided the FIFO is empty.
- Throughput: one word per cycle in and out. Back-to-back in_valid is fully supported.
- count, out_valid and overflow are registered, updating the cycle after the causing edge.
- overflow asserts the cycle after the dropped push and stays high until reset.

## Configuration
- DESKEW_DROP_CNT_EN
  - Defined:
    - Adds output drop_cnt, 16 bits.
    - drop_cnt counts dropped words, saturates at 16'hFFFF, and resets to 0.
    - It increments the cycle after each drop, in step with overflow.
  - Undefined: the port and counter are absent; overflow behaviour is unchanged.

## Test plan
- Single word, LANES=4, WIDTH=8:
  - Stimulus: in_valid at t=0; lane i driven with 8'h10+i at cycle i, all other lane inputs 0.
  - Required response: out_valid rises at t=4 with out_data=32'h13121110; with out_ready=1, out_valid falls at t=5 and count returns to 0.
- Streaming:
  - Stimulus: 20 back-to-back skewed words with a lane-0 ramp 0..19, out_ready=1 throughout.
  - Required response: 20 consecutive out_valid cycles starting at t=4, words in order, count ≤1, overflow=0.
- Fill, overflow and wrap:
  - Stimulus: 10 words with out_ready=0 (DEPTH=8).
  - Required response: count saturates at 8 and overflow=1 after word 9; draining yields exactly words 0..7 in order.
  - Follow-up: 8 more words exercise pointer wrap, with correct data.
- Full with simultaneous push and pop:
  - Stimulus: at count=8, push with out_ready=1.
  - Required response: count stays 8, no drop, overflow stays 0, next head is the second-oldest word.
- Mid-operation reset:
  - Stimulus: reset for one cycle with 3 words queued and 2 in flight.
  - Required response: next cycle count=0, out_valid=0, overflow=0; no in-flight word ever appears; a new word after reset arrives with latency 4.
- DESKEW_DROP_CNT_EN build:
  - Stimulus: 5 drops.
  - Required response: drop_cnt=5; reset returns it to 0.

Source files
------------

// File: rtl/deskew_collector.sv
// deskew_collector: realigns the diagonally skewed lane outputs of a systolic array into
// full-width words and queues them in a small FIFO with a valid/ready output handshake.
// Optional feature: define DESKEW_DROP_CNT_EN to add a saturating 16-bit drop counter output.
module deskew_collector #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [LANES*WIDTH-1:0]     in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*WIDTH-1:0]     out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
`ifdef DESKEW_DROP_CNT_EN
   ,
   output logic [15:0]                drop_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned SW = LANES * WIDTH;

   // Word with every lane lined up to the cycle in which push is asserted.
   logic [SW-1:0] aligned;

   // Lane i waits LANES-1-i cycles so that all lanes meet lane LANES-1.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int unsigned STAGES = LANES - 1 - i;
      if (STAGES == 0) begin : g_pass
         assign aligned[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_dly
         logic [WIDTH-1:0] sr_q [STAGES];
         logic [WIDTH-1:0] sr_d [STAGES];

         // Shift the lane one stage per cycle; the array never stalls.
         always_comb begin
            sr_d[0] = in_data[i*WIDTH +: WIDTH];
            for (int k = 1; k < int'(STAGES); k++) begin
               sr_d[k] = sr_q[k-1];
            end
         end

         // Delay-line state, cleared on reset so stale lanes never leak.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < int'(STAGES); k++) begin
                  sr_q[k] <= '0;
               end
            end else begin
               sr_q <= sr_d;
            end
         end

         assign aligned[i*WIDTH +: WIDTH] = sr_q[STAGES-1];
      end
   end

   // Valid pipeline: its last stage marks the cycle all lanes of a word are aligned.
   logic [LANES-2:0] vld_q, vld_d;
   logic             push;

   // Advance the valid pipeline alongside lane 0.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = in_valid;
      for (int k = 1; k < int'(LANES) - 1; k++) begin
         vld_d[k] = vld_q[k-1];
      end
      push = vld_q[LANES-2];
   end

   // Valid pipeline state; reset discards words in flight and masks in_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // FIFO state. Pointers carry one extra bit so full and empty are distinguishable.
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [SW-1:0] mem_q [DEPTH];
   logic [SW-1:0] mem_d [DEPTH];
   logic          overflow_q, overflow_d;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;

   // FIFO control: a push into a full FIFO only succeeds when a pop frees a slot.
   always_comb begin
      count      = wr_q - rd_q;
      out_valid  = (count != '0);
      full       = (count == PW'(DEPTH));
      pop        = out_valid && out_ready;
      push_ok    = push && (!full || pop);
      drop       = push && full && !pop;
      wr_d       = push_ok ? wr_q + PW'(1) : wr_q;
      rd_d       = pop ? rd_q + PW'(1) : rd_q;
      overflow_d = overflow_q | drop;
      mem_d      = mem_q;
      if (push_ok) begin
         mem_d[wr_q[AW-1:0]] = aligned;
      end
      out_data   = mem_q[rd_q[AW-1:0]];
      overflow   = overflow_q;
   end

   // Pointer and sticky overflow state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; empty slots are never presented as valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef DESKEW_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Count dropped words, holding at all-ones rather than wrapping.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
      drop_cnt = drop_cnt_q;
   end

   // Drop counter state.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif

endmodule
